// File: rtl/fifo_rd_ctrl.sv
// Drain-side controller for the 8-entry FIFO: pops one word at a time and offers it downstream on valid/ready.
// Optional macro FIFO_RD_TIMEOUT_EN adds a WAIT-state watchdog that turns a missing ack into an error.
module fifo_rd_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 4,
    parameter int TOT_W   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              err_flag,
    input  logic              err_clr,
    output logic [TOT_W-1:0]  rd_total
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_ISSUE = 3'b001,
        S_WAIT  = 3'b010,
        S_HOLD  = 3'b011,
        S_ERR   = 3'b100
    } state_t;

    state_t            state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              err_flag_q, err_flag_d;
    logic [TOT_W-1:0]  rd_total_q, rd_total_d;
    logic              has_data_s;
    logic              timeout_s;

    assign has_data_s = (fifo_count != {CNT_W{1'b0}});

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    assign timeout_s = (state_q == S_WAIT) && (tmr_q == TMR_W'(TIMEOUT - 1));

    // WAIT-cycle counter; any exit from WAIT (including the timeout itself) clears it
    always_comb begin
        tmr_d = {TMR_W{1'b0}};
        if ((state_q == S_WAIT) && !fifo_rd_ack && !fifo_rd_err && !timeout_s) begin
            tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            tmr_d = {TMR_W{1'b0}};
        end
    end

    // Timer register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= {TMR_W{1'b0}};
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    // Without the watchdog WAIT never times out; TIMEOUT is referenced only to keep it a live parameter
    assign timeout_s = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

    // Next-state and datapath decode
    always_comb begin
        state_d    = state_q;
        m_data_d   = m_data_q;
        rd_total_d = rd_total_q;
        err_flag_d = err_clr ? 1'b0 : err_flag_q;
        case (state_q)
            S_IDLE: begin
                if (enable && has_data_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_rd_err) begin
                    state_d = S_ERR;
                end else if (fifo_rd_ack) begin
                    state_d  = S_HOLD;
                    m_data_d = fifo_dout;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    rd_total_d = rd_total_q + {{(TOT_W-1){1'b0}}, 1'b1};
                    if (enable && has_data_s) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_ERR: begin
                err_flag_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they track the state register exactly
        rd_en_d   = (state_d == S_ISSUE);
        m_valid_d = (state_d == S_HOLD);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rd_en_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= {DATA_W{1'b0}};
            err_flag_q <= 1'b0;
            rd_total_q <= {TOT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            err_flag_q <= err_flag_d;
            rd_total_q <= rd_total_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign err_flag   = err_flag_q;
    assign rd_total   = rd_total_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: FIFO model plus a scoreboard of expected downstream words.
module tb_fifo_rd_ctrl;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int TOT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_dout = '0;
    logic              fifo_rd_ack = 1'b0;
    logic              fifo_rd_err = 1'b0;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              err_flag;
    logic              err_clr;
    logic [TOT_W-1:0]  rd_total;

    int tests = 0;
    int fails = 0;
    int pushed = 0;
    int popped = 0;
    int mode = 0;
    int rd_en_cnt = 0;
    int base;
    logic [DATA_W-1:0] mem_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] w5 [5];

    fifo_rd_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TOT_W(TOT_W), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_count(fifo_count),
        .fifo_dout(fifo_dout), .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_flag(err_flag), .err_clr(err_clr), .rd_total(rd_total)
    );

    always #5 clk = ~clk;

    assign fifo_count = CNT_W'(pushed - popped);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_fifo(input logic [DATA_W-1:0] w);
        mem_q.push_back(w);
        pushed++;
    endtask

    task automatic wait_total(input int target, input int max_cyc);
        int n = 0;
        while ((int'(rd_total) != target) && (n < max_cyc)) begin
            step(1);
            n++;
        end
        chk("wait_total", 64'(rd_total), 64'(target));
    endtask

    // FIFO model: answers a sampled rd_en one cycle later according to mode
    always @(posedge clk) begin
        fifo_rd_ack <= 1'b0;
        fifo_rd_err <= 1'b0;
        if (fifo_rd_en) begin
            if (mem_q.size() > 0) begin
                fifo_dout <= mem_q.pop_front();
                popped    <= popped + 1;
            end
            if (mode == 0) begin
                fifo_rd_ack <= 1'b1;
            end else if (mode == 1) begin
                fifo_rd_ack <= 1'b1;
                fifo_rd_err <= 1'b1;
            end
        end
    end

    // Monitor: read pulses, delivered words against the scoreboard, stability under backpressure
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                rd_en_cnt <= rd_en_cnt + 1;
                tests++;
                assert (fifo_count != '0) else begin
                    fails++;
                    $error("FAIL rd_en_empty: observed count %0d expected nonzero", fifo_count);
                end
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(m_valid), 64'(1));
                chk("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
                end
            end
            prev_hold <= m_valid && !m_ready;
            prev_data <= m_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        #3;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_total", 64'(rd_total), 64'(0));
        step(1);
        reset_n = 1'b1;
        step(2);

        // Single word: three-edge latency, one rd_en pulse
        enable = 1'b1;
        base = rd_en_cnt;
        push_fifo(32'h1234_5678); exp_q.push_back(32'h1234_5678);
        step(2);
        chk("single_not_yet", 64'(m_valid), 64'(0));
        step(1);
        chk("single_valid", 64'(m_valid), 64'(1));
        chk("single_data", 64'(m_data), 64'h1234_5678);
        m_ready = 1'b1;
        step(5);
        chk("single_total", 64'(rd_total), 64'(1));
        chk("single_rd_en", 64'(rd_en_cnt - base), 64'(1));
        chk("single_idle", 64'(m_valid), 64'(0));

        // Backpressure then a three-word burst
        m_ready = 1'b0;
        base = rd_en_cnt;
        push_fifo(32'hA000_0001); exp_q.push_back(32'hA000_0001);
        push_fifo(32'hA000_0002); exp_q.push_back(32'hA000_0002);
        push_fifo(32'hA000_0003); exp_q.push_back(32'hA000_0003);
        step(3);
        chk("bp_valid", 64'(m_valid), 64'(1));
        chk("bp_data", 64'(m_data), 64'hA000_0001);
        step(5);
        chk("bp_rd_en", 64'(rd_en_cnt - base), 64'(1));
        m_ready = 1'b1;
        wait_total(4, 30);
        step(3);
        chk("burst_rd_en", 64'(rd_en_cnt - base), 64'(3));
        chk("burst_sb_empty", 64'(exp_q.size()), 64'(0));

        // Error wins over a simultaneous ack
        mode = 1;
        push_fifo(32'hDEAD_0001);
        step(3);
        chk("err_no_valid", 64'(m_valid), 64'(0));
        step(1);
        chk("err_flag_set", 64'(err_flag), 64'(1));
        chk("err_total", 64'(rd_total), 64'(4));
        step(3);
        chk("err_still_set", 64'(err_flag), 64'(1));
        mode = 0;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("err_cleared", 64'(err_flag), 64'(0));

        // Enable dropped during WAIT: current word finishes, then park
        base = rd_en_cnt;
        for (int i = 0; i < 5; i++) begin
            w5[i] = 32'hC0DE_0000 + 32'(i);
            push_fifo(w5[i]);
        end
        exp_q.push_back(w5[0]);
        step(2);
        enable = 1'b0;
        step(10);
        chk("drop_total", 64'(rd_total), 64'(5));
        chk("drop_rd_en", 64'(rd_en_cnt - base), 64'(1));
        chk("drop_level", 64'(fifo_count), 64'(4));
        for (int i = 1; i < 5; i++) exp_q.push_back(w5[i]);
        enable = 1'b1;
        wait_total(9, 40);
        step(3);
        chk("drain_sb_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_level", 64'(fifo_count), 64'(0));

        // Missing ack
        mode = 2;
        base = rd_en_cnt;
        push_fifo(32'hBEEF_0001);
`ifdef FIFO_RD_TIMEOUT_EN
        step(5);
        chk("tmo_early", 64'(err_flag), 64'(0));
        step(2);
        chk("tmo_err", 64'(err_flag), 64'(1));
        chk("tmo_total", 64'(rd_total), 64'(9));
        chk("tmo_rd_en", 64'(rd_en_cnt - base), 64'(1));
`else
        step(100);
        chk("wait_no_err", 64'(err_flag), 64'(0));
        chk("wait_no_valid", 64'(m_valid), 64'(0));
        chk("wait_rd_en", 64'(rd_en_cnt - base), 64'(1));
`endif
        mode = 0;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(2);

        // Asynchronous reset in the middle of HOLD
        m_ready = 1'b0;
        push_fifo(32'hA5A5_A5A5);
        step(3);
        chk("pre_rst_data", 64'(m_data), 64'hA5A5_A5A5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(m_valid), 64'(0));
        chk("arst_data", 64'(m_data), 64'(0));
        chk("arst_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("arst_err", 64'(err_flag), 64'(0));
        chk("arst_total", 64'(rd_total), 64'(0));
        step(1);
        reset_n = 1'b1;
        step(2);
        chk("post_rst_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("post_rst_valid", 64'(m_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
